// File: rtl/bicintp_pkg.sv
// bicintp_pkg: shared width helpers, rounding offset and mode encoding for the bicubic pipe
package bicintp_pkg;
    localparam logic MODE_BICUBIC = 1'b0;
    localparam logic MODE_BYPASS  = 1'b1;

    // Vertical sum width: product width plus two bits of growth for four terms
    function automatic int vw(input int cw, input int wgt_w);
        return cw + wgt_w + 3;
    endfunction

    function automatic int acc_w(input int cw, input int wgt_w);
        return cw + 2 * wgt_w + 5;
    endfunction

    // Half an LSB of the final result, for round-half-up before the shift
    function automatic int rnd_off(input int wgt_frac);
        return 1 << (2 * wgt_frac - 1);
    endfunction
endpackage

// File: rtl/bicintp_cal_pipe_if.sv
// bicintp_cal_pipe_if: column-beat input stream and result stream of the bicubic pipe
// master drives beats (mode, in_valid, in_last, p0..p3, w_y_0..w_y_3, w_x) and out_ready;
// slave returns in_ready, out_valid, out_data and the err pulse
interface bicintp_cal_pipe_if #(
    parameter int CH    = 3,
    parameter int CW    = 8,
    parameter int WGT_W = 8
);
    localparam int PW = CH * CW;
    logic                    mode;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [PW-1:0]           p0, p1, p2, p3;
    logic signed [WGT_W-1:0] w_y_0, w_y_1, w_y_2, w_y_3, w_x;
    logic                    out_valid;
    logic                    out_ready;
    logic [PW-1:0]           out_data;
    logic                    err;

    modport master (
        output mode, in_valid, in_last, p0, p1, p2, p3, w_y_0, w_y_1, w_y_2, w_y_3, w_x, out_ready,
        input  in_ready, out_valid, out_data, err
    );
    modport slave (
        input  mode, in_valid, in_last, p0, p1, p2, p3, w_y_0, w_y_1, w_y_2, w_y_3, w_x, out_ready,
        output in_ready, out_valid, out_data, err
    );
endinterface

// File: rtl/bicintp_chan_mac.sv
// bicintp_chan_mac: one colour channel of the 4x4 bicubic MAC with round and clamp
// sys_clk clock; en advances S1-S3; acc_en/acc_first update the window accumulator;
// pix/wy are the registered column beat, wx its horizontal weight; res is the clamped result
module bicintp_chan_mac
    import bicintp_pkg::*;
#(
    parameter int CW       = 8,
    parameter int WGT_W    = 8,
    parameter int WGT_FRAC = 6
) (
    input  logic                    sys_clk,
    input  logic                    en,
    input  logic                    acc_en,
    input  logic                    acc_first,
    input  logic [CW-1:0]           pix [4],
    input  logic signed [WGT_W-1:0] wy [4],
    input  logic signed [WGT_W-1:0] wx,
    output logic [CW-1:0]           res
);
    localparam int PRW = CW + WGT_W + 1;
    localparam int VWL = vw(CW, WGT_W);
    localparam int HW  = VWL + WGT_W;
    localparam int AW  = acc_w(CW, WGT_W);

    logic signed [PRW-1:0]   prod [4];
    logic signed [WGT_W-1:0] wx1, wx2;
    logic signed [VWL-1:0]   vsum;
    logic signed [HW-1:0]    hprod;
    logic signed [AW-1:0]    acc, r;

    always_ff @(posedge sys_clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) prod[i] <= PRW'($signed({1'b0, pix[i]})) * PRW'(wy[i]);
            wx1   <= wx;
            vsum  <= VWL'(prod[0]) + VWL'(prod[1]) + VWL'(prod[2]) + VWL'(prod[3]);
            wx2   <= wx1;
            hprod <= HW'(vsum) * HW'(wx2);
        end
        if (acc_en) acc <= acc_first ? AW'(hprod) : acc + AW'(hprod);
    end

    always_comb begin
        r   = (acc + AW'(rnd_off(WGT_FRAC))) >>> (2 * WGT_FRAC);
        res = r[AW-1] ? '0 : (|r[AW-2:CW]) ? '1 : r[CW-1:0];
    end
endmodule

// File: rtl/bicintp_cal_pipe.sv
// bicintp_cal_pipe: streaming 4x4 bicubic interpolator with flow control, bypass and beat-alignment check
// sys_clk clock, sys_rst synchronous active-high reset; bus carries the column-beat input
// stream and the result stream (see bicintp_cal_pipe_if)
module bicintp_cal_pipe
    import bicintp_pkg::*;
#(
    parameter int CH       = 3,
    parameter int CW       = 8,
    parameter int WGT_W    = 8,
    parameter int WGT_FRAC = 6
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    bicintp_cal_pipe_if.slave bus
);
    localparam int PW = CH * CW;

    typedef struct packed {
        logic          v;
        logic [1:0]    b;
        logic          m;
        logic [PW-1:0] pix;
    } tag_t;

    // tag[0] sits with the input registers, tag[4] with the accumulators
    tag_t                    tag [5];
    logic [1:0]              bcnt;
    logic                    mode_lat, en, acc, mis;
    logic [PW-1:0]           p_q [4];
    logic signed [WGT_W-1:0] wy_q [4];
    logic signed [WGT_W-1:0] wx_q;
    logic [PW-1:0]           byp, res;

    assign en           = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = en;
    assign acc          = bus.in_valid && en;
    assign mis          = bus.in_last != (bcnt == 2'd3);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bcnt          <= 2'd0;
            mode_lat      <= MODE_BICUBIC;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            for (int i = 0; i < 5; i++) tag[i].v <= 1'b0;
        end else begin
            bus.err <= acc && mis;
            // A misaligned beat is dropped and restarts framing; the partial window never reaches beat 3
            if (acc) bcnt <= mis ? 2'd0 : bcnt + 2'd1;
            if (acc && !mis && bcnt == 2'd0) mode_lat <= bus.mode;
            if (en) begin
                tag[0] <= '{v: acc && !mis, b: bcnt, m: (bcnt == 2'd0) ? bus.mode : mode_lat, pix: bus.p1};
                for (int i = 1; i < 5; i++) tag[i] <= tag[i-1];
                p_q  <= '{bus.p0, bus.p1, bus.p2, bus.p3};
                wy_q <= '{bus.w_y_0, bus.w_y_1, bus.w_y_2, bus.w_y_3};
                wx_q <= bus.w_x;
                if (tag[3].v && tag[3].b == 2'd1) byp <= tag[3].pix;
                bus.out_valid <= tag[4].v && tag[4].b == 2'd3;
                if (tag[4].v && tag[4].b == 2'd3) bus.out_data <= (tag[4].m == MODE_BYPASS) ? byp : res;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CW-1:0] cp [4];
        for (genvar r = 0; r < 4; r++) begin : g_r
            assign cp[r] = p_q[r][c*CW +: CW];
        end
        bicintp_chan_mac #(.CW(CW), .WGT_W(WGT_W), .WGT_FRAC(WGT_FRAC)) u_mac (
            .sys_clk   (sys_clk),
            .en        (en),
            .acc_en    (en && tag[3].v),
            .acc_first (tag[3].b == 2'd0),
            .pix       (cp),
            .wy        (wy_q),
            .wx        (wx_q),
            .res       (res[c*CW +: CW])
        );
    end
endmodule
